// File: rtl/pwm_dac_modulator.sv
// pwm_dac_modulator: turns 8-bit waveform samples into a PWM bitstream for
// an RC-filter DAC. A period is 256 count steps of PRESCALE clocks each; the
// output is high for the first duty steps of the period and low for the rest.
// A new sample is taken only at the start of a period, so mid-period changes
// on sample_in never distort the waveform already being emitted.
//
// Handshake: sample_in has no valid/ready pair. The upstream generator keeps
// sample_in stable and valid at all times; sample_req is a one-clock strobe,
// high in the clock after the edge that latched sample_in, telling upstream
// that it may advance to its next sample.
module pwm_dac_modulator #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sample_in,
  output logic       pwm_out,
  output logic       sample_req
);

  // Prescaler width covers 0..PRESCALE-1; keep at least one bit for PRESCALE=1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    cnt;
  logic [7:0]    duty;

  logic          tick;
  logic          period_start;
  logic [7:0]    duty_eff;

  // Step and period-start qualifiers, plus the duty value that applies at
  // this edge (the incoming sample on a period start, else the latched one).
  always_comb begin
    tick         = en && (pre_cnt == PRE_MAX);
    period_start = en && (cnt == 8'd0) && (pre_cnt == '0);
    duty_eff     = period_start ? sample_in : duty;
  end

  // Counters, sample latch and registered outputs; reset beats enable, and a
  // disabled edge clears position so re-enable always begins a fresh period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt    <= '0;
      cnt        <= 8'd0;
      duty       <= 8'd0;
      pwm_out    <= 1'b0;
      sample_req <= 1'b0;
    end else if (!en) begin
      pre_cnt    <= '0;
      cnt        <= 8'd0;
      pwm_out    <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        cnt     <= cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
      if (period_start) begin
        duty <= sample_in;
      end
      sample_req <= period_start;
      pwm_out    <= (cnt < duty_eff);
    end
  end

endmodule

// File: tb/tb_pwm_dac_modulator.sv
// tb_pwm_dac_modulator: drives two modulators (PRESCALE=1 and PRESCALE=4)
// from shared stimulus. A reference model, written in terms of position
// within a 256*PRESCALE-clock period, pushes the expected {sample_req,
// pwm_out} for each edge into a per-instance queue; a monitor pops and
// compares just after every rising edge.
module tb_pwm_dac_modulator;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] sample_in;
  logic       pwm1, req1;
  logic       pwm4, req4;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q1[$];
  logic [1:0] exp_q4[$];

  // Reference model state per instance.
  bit act1, act4;
  int pos1, pos4;
  int duty1, duty4;
  int cyc = 0;

  pwm_dac_modulator #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
    .pwm_out(pwm1), .sample_req(req1)
  );

  pwm_dac_modulator #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
    .pwm_out(pwm4), .sample_req(req4)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: position counts clocks since the period start; a new period
  // begins whenever position is 0 (first enabled edge or after 256*p clocks).
  task automatic ref_step(input int p, input logic r, input logic e,
                          input logic [7:0] s, input bit act_i,
                          input int pos_i, input int duty_i,
                          output bit act_o, output int pos_o,
                          output int duty_o, output logic [1:0] exp_o);
    act_o  = act_i;
    pos_o  = pos_i;
    duty_o = duty_i;
    exp_o  = 2'b00;
    if (!r) begin
      act_o  = 0;
      pos_o  = 0;
      duty_o = 0;
    end else if (!e) begin
      act_o = 0;
      pos_o = 0;
    end else begin
      if (!act_o) pos_o = 0;
      act_o = 1;
      if (pos_o == 0) begin
        duty_o   = int'(s);
        exp_o[1] = 1'b1;
      end
      exp_o[0] = (pos_o < duty_o * p);
      pos_o = (pos_o + 1) % (256 * p);
    end
  endtask

  // Driver: apply inputs for the next rising edge and queue the expectation.
  task automatic drive(input logic r, input logic e, input logic [7:0] s);
    logic [1:0] x1, x4;
    @(negedge clk);
    rst       = r;
    en        = e;
    sample_in = s;
    ref_step(1, r, e, s, act1, pos1, duty1, act1, pos1, duty1, x1);
    ref_step(4, r, e, s, act4, pos4, duty4, act4, pos4, duty4, x4);
    exp_q1.push_back(x1);
    exp_q4.push_back(x4);
  endtask

  task automatic run(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, s);
  endtask

  // Scoreboard monitor: compare each instance's registered outputs after the edge.
  always @(posedge clk) begin
    logic [1:0] e1, e4;
    #1;
    cyc++;
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      checks++;
      if ({req1, pwm1} !== e1) begin
        errors++;
        $display("FAIL p1_req_pwm cyc=%0d got=%b%b expected=%b", cyc, req1, pwm1, e1);
      end
    end
    if (exp_q4.size() > 0) begin
      e4 = exp_q4.pop_front();
      checks++;
      if ({req4, pwm4} !== e4) begin
        errors++;
        $display("FAIL p4_req_pwm cyc=%0d got=%b%b expected=%b", cyc, req4, pwm4, e4);
      end
    end
  end

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    sample_in = 8'd0;
    act1 = 0; act4 = 0; pos1 = 0; pos4 = 0; duty1 = 0; duty4 = 0;

    // Reset state, with en high to show reset priority.
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd77);
    drive(1'b0, 1'b1, 8'd77);

    // Duty 64 steady for two P1 periods.
    run(512, 8'd64);
    // Mid-period change 64 -> 200 at clock 100 of a period.
    run(100, 8'd64);
    run(412, 8'd200);
    // Extremes.
    run(512, 8'd0);
    run(512, 8'd255);
    // Duty 10, more than two P4 periods.
    run(2100, 8'd10);

    // en dropped at cnt=30 for 5 clocks (restart first so P1 is at cnt 0).
    drive(1'b1, 1'b0, 8'd90);
    run(30, 8'd90);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'd150);
    run(300, 8'd150);

    // Reset mid-period at cnt=120.
    drive(1'b1, 1'b0, 8'd180);
    run(120, 8'd180);
    drive(1'b0, 1'b1, 8'd33);
    drive(1'b0, 1'b1, 8'd33);
    run(300, 8'd33);

    // Randomized: samples change every clock, occasional en drops and resets.
    for (int i = 0; i < 4000; i++) begin
      logic r, e;
      r = ($urandom_range(0, 499) != 0);
      e = ($urandom_range(0, 199) != 0);
      drive(r, e, 8'($urandom_range(0, 255)));
    end
    // Random steady duties across both instances' full periods.
    for (int k = 0; k < 3; k++) run(1100, 8'($urandom_range(0, 255)));

    @(posedge clk);
    #2;
    checks++;
    if (exp_q1.size() != 0 || exp_q4.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d/%0d expected=0/0", exp_q1.size(), exp_q4.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_dac_modulator.md
PWM_DAC_MODULATOR -- requirements
Module: pwm_dac_modulator

Interface
REQ-001 SHALL have parameter PRESCALE, default 1: clocks per PWM count step (legal range 1..256).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: modulator enable.
REQ-005 SHALL have port sample_in, input, 8 bits: unsigned waveform sample from the upstream waveform generator output.
REQ-006 SHALL have port pwm_out, output, 1 bit: registered PWM bitstream for the RC-filter DAC.
REQ-007 SHALL have port sample_req, output, 1 bit: one-clock strobe marking the cycle in which sample_in was latched.

Function
REQ-008 SHALL hold internal registers pre_cnt (prescaler, 0..PRESCALE-1), cnt (8-bit period counter) and duty (8-bit latched sample).
REQ-009 SHALL define tick as en=1 and pre_cnt=PRESCALE-1.
REQ-010 SHALL increment pre_cnt when en=1 and not tick, and clear it to 0 on tick.
REQ-011 SHALL increment cnt modulo 256 on tick, with 255 wrapping to 0, and hold cnt otherwise.
REQ-012 SHALL define period start as an edge with en=1, cnt=0 and pre_cnt=0.
REQ-013 SHALL latch duty <= sample_in at period start.
REQ-014 SHALL ignore sample_in at all other edges; mid-period changes take effect only at the next period start.
REQ-015 SHALL set sample_req to 1 for exactly the clock following a period-start edge, and 0 otherwise.
REQ-016 SHALL register pwm_out <= (cnt < duty_eff) at each edge with en=1, where duty_eff = sample_in at period start and duty otherwise.
REQ-017 SHALL compare cnt and duty_eff as 8-bit unsigned values.
REQ-018 SHALL give a period of exactly 256*PRESCALE clocks.
REQ-019 SHALL give a high time of exactly duty*PRESCALE clocks per period, high first and then low.
REQ-020 SHALL produce these boundary behaviours:
  - duty=0: pwm_out stays 0 for the whole period.
  - duty=255: pwm_out is high 255*PRESCALE clocks and low PRESCALE clocks.
  - No glitch at wrap; the high phase of the next period starts on the edge after the last low cycle.
REQ-021 SHALL apply latency: pwm_out and sample_req change one clock after the edge that evaluates them; the first enabled edge is a period start.
REQ-022 SHALL, on an edge with en=0, apply all of the following:
  - pre_cnt <= 0, cnt <= 0, pwm_out <= 0, sample_req <= 0.
  - duty holds its value.
REQ-023 SHALL restart on re-enable: the first edge with en=1 after en=0 is a period start, and a partial period is never resumed.
REQ-024 SHALL derive PRESCALE=1 behaviour from the same rules, with tick on every enabled edge.

Reset
REQ-025 SHALL, on an edge with rst=0, set pre_cnt=0, cnt=0, duty=0, pwm_out=0, sample_req=0.
REQ-026 SHALL give rst priority over en.
REQ-027 SHALL make the first edge with rst=1 and en=1 a period start.
REQ-028 SHALL abandon any in-progress period on reset without emitting a further sample_req.

Verification
REQ-029 SHALL cover duty 64 at PRESCALE=1:
  - Stimulus: en=1, sample_in=64 held.
  - Response: pwm_out high 64 clocks then low 192, repeating every 256 clocks.
  - Response: sample_req pulses once per 256 clocks, aligned to the first high clock.
REQ-030 SHALL cover a mid-period sample change:
  - Stimulus: sample_in 64 -> 200 at clock 100 of a period.
  - Response: current period stays 64 high / 192 low.
  - Response: next period is 200 high / 56 low.
REQ-031 SHALL cover the duty extremes:
  - Stimulus: sample_in=0, then 255.
  - Response: with 0, pwm_out never rises.
  - Response: with 255, pwm_out is low for exactly 1 clock per 256.
REQ-032 SHALL cover PRESCALE=4 with sample_in=10:
  - Response: period 1024 clocks, high 40 clocks.
  - Response: sample_req spacing 1024 clocks.
REQ-033 SHALL cover en dropped mid-period:
  - Stimulus: en=0 for 5 clocks at cnt=30, then en=1.
  - Response: pwm_out=0 the clock after the drop.
  - Response: on re-enable, sample_req pulses and a full fresh period follows.
REQ-034 SHALL cover reset mid-period:
  - Stimulus: rst=0 for 2 clocks at cnt=120 with en=1.
  - Response: pwm_out=0 and sample_req=0 during reset.
  - Response: after release, duty latches the current sample_in with a sample_req pulse on the first clock.
